// File: rtl/counter_updown_cfg.sv
// Up/down counter with runtime upper bound, runtime step, synchronous load and
// compile-time saturate/wrap behaviour at the bounds, plus one-cycle ovf/unf pulses.
module counter_updown_cfg #(
    parameter int unsigned N        = 8,
    parameter int unsigned SATURATE = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic         i_up,
    input  logic [N-1:0] i_step,
    input  logic         i_load,
    input  logic [N-1:0] i_load_val,
    input  logic [N-1:0] i_max_val,
    output logic [N-1:0] o_out,
    output logic         o_at_max,
    output logic         o_at_min,
    output logic         o_ovf,
    output logic         o_unf
);

    logic [N-1:0] r_out;
    logic         r_ovf;
    logic         r_unf;

    logic [N:0]   w_sum;
    logic [N-1:0] w_out_nxt;
    logic         w_ovf_nxt;
    logic         w_unf_nxt;

    // One extra bit so an up-count past the top of the range is never lost.
    assign w_sum = {1'b0, r_out} + {1'b0, i_step};

    always_comb begin
        w_out_nxt = r_out;
        w_ovf_nxt = 1'b0;
        w_unf_nxt = 1'b0;
        if (i_load) begin
            w_out_nxt = (i_load_val > i_max_val) ? i_max_val : i_load_val;
        end else if (i_en) begin
            if (r_out > i_max_val) begin
                // Bound was lowered under us: clamp silently.
                w_out_nxt = i_max_val;
            end else if (i_up) begin
                if (w_sum <= {1'b0, i_max_val}) begin
                    w_out_nxt = w_sum[N-1:0];
                end else begin
                    w_ovf_nxt = 1'b1;
                    w_out_nxt = (SATURATE != 0) ? i_max_val : '0;
                end
            end else begin
                if (i_step <= r_out) begin
                    w_out_nxt = r_out - i_step;
                end else begin
                    w_unf_nxt = 1'b1;
                    w_out_nxt = (SATURATE != 0) ? '0 : i_max_val;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_out <= w_out_nxt;
            r_ovf <= w_ovf_nxt;
            r_unf <= w_unf_nxt;
        end
    end

    assign o_out    = r_out;
    assign o_ovf    = r_ovf;
    assign o_unf    = r_unf;
    assign o_at_max = (r_out == i_max_val);
    assign o_at_min = (r_out == '0);

endmodule

// File: tb/tb_counter_updown_cfg.sv
// Bench for counter_updown_cfg: four instances (N=8/4, saturate/wrap) share one stimulus
// stream; an integer model is compared every cycle, with directed literal checks on top.
module tb_counter_updown_cfg;

    logic       clk = 1'b0;
    logic       rst, en, up, load;
    logic [7:0] step, lv, mx;

    logic [7:0] out_s8, out_w8;
    logic [3:0] out_s4, out_w4;
    logic [3:0] amx, amn, ovf, unf;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model state per instance: 0=N8 sat, 1=N8 wrap, 2=N4 sat, 3=N4 wrap.
    int m_out [4];
    int m_ovf [4];
    int m_unf [4];
    int width [4] = '{8, 8, 4, 4};
    int satur [4] = '{1, 0, 1, 0};

    always #5 clk = ~clk;

    counter_updown_cfg #(.N(8), .SATURATE(1)) u_s8 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_up(up), .i_step(step), .i_load(load),
        .i_load_val(lv), .i_max_val(mx), .o_out(out_s8), .o_at_max(amx[0]),
        .o_at_min(amn[0]), .o_ovf(ovf[0]), .o_unf(unf[0])
    );
    counter_updown_cfg #(.N(8), .SATURATE(0)) u_w8 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_up(up), .i_step(step), .i_load(load),
        .i_load_val(lv), .i_max_val(mx), .o_out(out_w8), .o_at_max(amx[1]),
        .o_at_min(amn[1]), .o_ovf(ovf[1]), .o_unf(unf[1])
    );
    counter_updown_cfg #(.N(4), .SATURATE(1)) u_s4 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_up(up), .i_step(step[3:0]), .i_load(load),
        .i_load_val(lv[3:0]), .i_max_val(mx[3:0]), .o_out(out_s4), .o_at_max(amx[2]),
        .o_at_min(amn[2]), .o_ovf(ovf[2]), .o_unf(unf[2])
    );
    counter_updown_cfg #(.N(4), .SATURATE(0)) u_w4 (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_up(up), .i_step(step[3:0]), .i_load(load),
        .i_load_val(lv[3:0]), .i_max_val(mx[3:0]), .o_out(out_w4), .o_at_max(amx[3]),
        .o_at_min(amn[3]), .o_ovf(ovf[3]), .o_unf(unf[3])
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the rules, masked to each width.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            int mask, s, l, m, o;
            mask = (1 << width[i]) - 1;
            s = int'(step) & mask;
            l = int'(lv) & mask;
            m = int'(mx) & mask;
            o = m_out[i];
            m_ovf[i] = 0;
            m_unf[i] = 0;
            if (rst) begin
                o = 0;
            end else if (load) begin
                o = (l < m) ? l : m;
            end else if (en) begin
                if (o > m) begin
                    o = m;
                end else if (up) begin
                    if (o + s <= m) o = o + s;
                    else begin
                        m_ovf[i] = 1;
                        o = satur[i] ? m : 0;
                    end
                end else begin
                    if (s <= o) o = o - s;
                    else begin
                        m_unf[i] = 1;
                        o = satur[i] ? 0 : m;
                    end
                end
            end
            m_out[i] = o;
        end
    end

    function automatic int act_out(input int i);
        case (i)
            0: return int'(out_s8);
            1: return int'(out_w8);
            2: return int'(out_s4);
            default: return int'(out_w4);
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 4; i++) begin
                int m;
                m = int'(mx) & ((1 << width[i]) - 1);
                check($sformatf("model out[%0d]", i), act_out(i), m_out[i]);
                check($sformatf("model ovf[%0d]", i), int'(ovf[i]), m_ovf[i]);
                check($sformatf("model unf[%0d]", i), int'(unf[i]), m_unf[i]);
                check($sformatf("model at_max[%0d]", i), int'(amx[i]), int'(m_out[i] == m));
                check($sformatf("model at_min[%0d]", i), int'(amn[i]), int'(m_out[i] == 0));
            end
        end
    end

    // Inputs change 2 time units after the active edge; results of an edge are visible then.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; load = 1'b1; up = 1'b1;
        step = 8'd3; lv = 8'd5; mx = 8'd10;
        cyc();
        chk_en = 1'b1;
        cyc();
        check("reset out", int'(out_s8), 0);
        check("reset ovf", int'(ovf[0]), 0);
        check("reset unf", int'(unf[0]), 0);
        check("reset at_min", int'(amn[0]), 1);
        check("reset at_max", int'(amx[0]), 0);

        rst = 1'b0; en = 1'b0; load = 1'b0;
        for (int k = 0; k < 5; k++) cyc();
        check("hold out", int'(out_s8), 0);

        // Saturating and wrapping up-count, step 3, bound 10.
        en = 1'b1; up = 1'b1; step = 8'd3;
        cyc(); check("up 1st", int'(out_s8), 3);
        cyc(); check("up 2nd", int'(out_s8), 6);
        cyc(); check("up 3rd", int'(out_s8), 9);
        check("at_max before bound", int'(amx[0]), 0);
        cyc(); check("sat 4th", int'(out_s8), 10);
        check("sat 4th ovf", int'(ovf[0]), 1);
        check("sat 4th at_max", int'(amx[0]), 1);
        check("wrap 4th", int'(out_w8), 0);
        check("wrap 4th ovf", int'(ovf[1]), 1);
        cyc(); check("sat 5th", int'(out_s8), 10);
        check("sat 5th ovf", int'(ovf[0]), 1);
        step = 8'd0;
        cyc(); check("step0 bound out", int'(out_s8), 10);
        check("step0 bound ovf", int'(ovf[0]), 0);

        // Wrap mode, step 4.
        load = 1'b1; lv = 8'd8; en = 1'b0;
        cyc(); check("load 8", int'(out_w8), 8);
        load = 1'b0; en = 1'b1; up = 1'b1; step = 8'd4;
        cyc(); check("wrap up out", int'(out_w8), 0);
        check("wrap up ovf", int'(ovf[1]), 1);
        en = 1'b0;
        cyc(); check("ovf one cycle", int'(ovf[1]), 0);
        load = 1'b1; lv = 8'd2;
        cyc();
        load = 1'b0; en = 1'b1; up = 1'b0;
        cyc(); check("wrap down out", int'(out_w8), 10);
        check("wrap down unf", int'(unf[1]), 1);
        check("sat down out", int'(out_s8), 0);
        load = 1'b1; lv = 8'd4; en = 1'b0;
        cyc();
        load = 1'b0; en = 1'b1;
        cyc(); check("exact zero out", int'(out_w8), 0);
        check("exact zero unf", int'(unf[1]), 0);

        // Load priority and clipping.
        load = 1'b1; lv = 8'd7; en = 1'b1; up = 1'b1;
        cyc(); check("load over en", int'(out_s8), 7);
        check("load no ovf", int'(ovf[0]), 0);
        lv = 8'd200;
        cyc(); check("load clipped", int'(out_s8), 10);
        rst = 1'b1;
        cyc(); check("rst over load", int'(out_s8), 0);
        rst = 1'b0;

        // Runtime bound lowered below current count.
        lv = 8'd9;
        cyc(); check("load 9", int'(out_s8), 9);
        load = 1'b0; en = 1'b0; mx = 8'd5;
        #1;
        check("at_max after lower", int'(amx[0]), 0);
        #1;
        en = 1'b1; up = 1'b0; step = 8'd2;
        cyc(); check("clamp out", int'(out_s8), 5);
        check("clamp unf", int'(unf[0]), 0);
        check("clamp ovf", int'(ovf[0]), 0);
        check("clamp at_max", int'(amx[0]), 1);

        // max_val = 0 pins the counter.
        mx = 8'd0; up = 1'b1; step = 8'd1;
        cyc(); cyc(); check("pinned out", int'(out_s8), 0);
        check("pinned ovf", int'(ovf[0]), 1);

        // Random regression.
        for (int k = 0; k < 10000; k++) begin
            rst  = ($urandom_range(63) == 0);
            load = ($urandom_range(15) == 0);
            en   = ($urandom_range(3) != 0);
            up   = 1'($urandom_range(1));
            step = ($urandom_range(3) == 0) ? 8'($urandom) : 8'($urandom_range(4));
            lv   = 8'($urandom);
            if ($urandom_range(31) == 0)
                mx = ($urandom_range(3) == 0) ? 8'($urandom_range(3)) : 8'($urandom);
            cyc();
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
